riscv_perf_counter_unit: RTL and testbench

Parametrised hardware performance-monitoring unit for the RI5CY core. It provides `N_COUNTERS` wide event counters, each fed by a software-selectable event from an `N_EVENTS`-wide event bus. Counters support wrap or saturate modes and sticky overflow flags with a maskable interrupt. The unit sits beside the CSR file and answers the 0x780–0x7A3 CSR window; the CSR file muxes `csr_rdata_o` in when `csr_hit_o` is high.

---
 rtl/riscv_perf_counter_unit.sv | 154 +++++++++++++++
 tb/tb_riscv_perf_counter_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_perf_counter_unit.sv
// riscv_perf_counter_unit: CSR-mapped event counters with wrap/saturate, sticky overflow and IRQ.
// Optional macro PERF_SHADOW_READ_EN: a low-word read latches the high word for an atomic 64-bit read.
module riscv_perf_counter_unit #(
    parameter int N_COUNTERS = 4,
    parameter int N_EVENTS   = 16,
    parameter int CNT_WIDTH  = 48
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                csr_access_i,
    input  logic [11:0]         csr_addr_i,
    input  logic [31:0]         csr_wdata_i,
    input  logic [1:0]          csr_op_i,
    output logic [31:0]         csr_rdata_o,
    output logic                csr_hit_o,
    input  logic [N_EVENTS-1:0] event_i,
    output logic                ovf_irq_o
);
    localparam int HW = CNT_WIDTH - 32;
    localparam logic [1:0] CSR_OP_NONE  = 2'b00;
    localparam logic [1:0] CSR_OP_WRITE = 2'b01;
    localparam logic [1:0] CSR_OP_SET   = 2'b10;
    localparam logic [1:0] CSR_OP_CLEAR = 2'b11;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    function automatic logic [31:0] csr_apply(input logic [31:0] old_v,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  op);
        case (op)
            CSR_OP_WRITE: csr_apply = wdata;
            CSR_OP_SET:   csr_apply = old_v | wdata;
            CSR_OP_CLEAR: csr_apply = old_v & ~wdata;
            default:      csr_apply = old_v;
        endcase
    endfunction

    logic [N_COUNTERS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [N_COUNTERS-1:0][7:0]           evsel_q, evsel_d;
    logic [1:0]                           ctrl_q, ctrl_d;
    logic [N_COUNTERS-1:0]                ovfie_q, ovfie_d, ovf_q, ovf_d, ovf_set;
    logic [N_EVENTS-1:0]                  ev_q;
    logic [255:0]                         ev_ext;

    logic [2:0]           idx;
    logic                 idx_ok;
    logic                 sel_lo, sel_hi, sel_ev, sel_ctrl, sel_ovfie, sel_ovf, csr_we;
    logic [CNT_WIDTH-1:0] sel_cnt;
    logic [7:0]           sel_evsel;
    logic [31:0]          hi_rd;

    assign idx       = csr_addr_i[2:0];
    assign idx_ok    = {29'd0, idx} < N_COUNTERS;
    assign sel_lo    = (csr_addr_i[11:3] == 9'h0F0) && idx_ok;
    assign sel_hi    = (csr_addr_i[11:3] == 9'h0F1) && idx_ok;
    assign sel_ev    = (csr_addr_i[11:3] == 9'h0F2) && idx_ok;
    assign sel_ctrl  = (csr_addr_i == 12'h7A1);
    assign sel_ovfie = (csr_addr_i == 12'h7A2);
    assign sel_ovf   = (csr_addr_i == 12'h7A3);
    assign csr_hit_o = csr_access_i && (sel_lo || sel_hi || sel_ev || sel_ctrl || sel_ovfie || sel_ovf);
    assign csr_we    = csr_hit_o && (csr_op_i != CSR_OP_NONE);

    // Zero-padded so any 8-bit EVSEL can index safely; out-of-range selects are masked below.
    assign ev_ext = 256'(ev_q);

    for (genvar gi = 0; gi < N_COUNTERS; gi++) begin : g_cnt
        logic           idx_match, wr_lo, wr_hi, inc, at_max;
        logic [31:0]    lo_new;
        logic [HW-1:0]  hi_new;
        logic [7:0]     ev_new;

        assign idx_match = (idx == 3'(gi));
        assign wr_lo     = csr_we && sel_lo && idx_match;
        assign wr_hi     = csr_we && sel_hi && idx_match;
        assign lo_new    = csr_apply(cnt_q[gi][31:0], csr_wdata_i, csr_op_i);
        assign hi_new    = HW'(csr_apply(32'(cnt_q[gi][CNT_WIDTH-1:32]), csr_wdata_i, csr_op_i));
        assign ev_new    = 8'(csr_apply({24'd0, evsel_q[gi]}, csr_wdata_i, csr_op_i));
        assign at_max    = &cnt_q[gi];
        assign inc       = ctrl_q[0] && ({24'd0, evsel_q[gi]} < N_EVENTS) && ev_ext[evsel_q[gi]];

        // A software write to either word swallows the same-cycle increment and its overflow.
        assign ovf_set[gi] = inc && at_max && !wr_lo && !wr_hi;
        assign cnt_d[gi]   = wr_lo ? {cnt_q[gi][CNT_WIDTH-1:32], lo_new}
                           : wr_hi ? {hi_new, cnt_q[gi][31:0]}
                           : (inc && !(ctrl_q[1] && at_max)) ? cnt_q[gi] + CNT_ONE
                           : cnt_q[gi];
        assign evsel_d[gi] = (csr_we && sel_ev && idx_match) ? ev_new : evsel_q[gi];
    end

    assign ctrl_d  = (csr_we && sel_ctrl) ? 2'(csr_apply({30'd0, ctrl_q}, csr_wdata_i, csr_op_i)) : ctrl_q;
    assign ovfie_d = (csr_we && sel_ovfie) ? N_COUNTERS'(csr_apply(32'(ovfie_q), csr_wdata_i, csr_op_i)) : ovfie_q;
    // Hardware overflow set takes priority over a same-cycle software clear.
    assign ovf_d   = ((csr_we && sel_ovf) ? N_COUNTERS'(csr_apply(32'(ovf_q), csr_wdata_i, csr_op_i)) : ovf_q)
                     | ovf_set;

    assign ovf_irq_o = |(ovf_q & ovfie_q);

    always_comb begin
        sel_cnt   = '0;
        sel_evsel = '0;
        for (int k = 0; k < N_COUNTERS; k++) begin
            if (idx == 3'(k)) begin
                sel_cnt   = cnt_q[k];
                sel_evsel = evsel_q[k];
            end
        end
    end

`ifdef PERF_SHADOW_READ_EN
    logic [HW-1:0] shadow_q, shadow_d;

    assign shadow_d = (csr_hit_o && sel_lo) ? sel_cnt[CNT_WIDTH-1:32] : shadow_q;
    assign hi_rd    = 32'(shadow_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`else
    assign hi_rd = 32'(sel_cnt[CNT_WIDTH-1:32]);
`endif

    always_comb begin
        csr_rdata_o = '0;
        if (csr_hit_o) begin
            if (sel_lo)         csr_rdata_o = sel_cnt[31:0];
            else if (sel_hi)    csr_rdata_o = hi_rd;
            else if (sel_ev)    csr_rdata_o = {24'd0, sel_evsel};
            else if (sel_ctrl)  csr_rdata_o = {30'd0, ctrl_q};
            else if (sel_ovfie) csr_rdata_o = 32'(ovfie_q);
            else if (sel_ovf)   csr_rdata_o = 32'(ovf_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            evsel_q <= {N_COUNTERS{8'hFF}};
            ctrl_q  <= 2'b01;
            ovfie_q <= '0;
            ovf_q   <= '0;
            ev_q    <= '0;
        end else begin
            cnt_q   <= cnt_d;
            evsel_q <= evsel_d;
            ctrl_q  <= ctrl_d;
            ovfie_q <= ovfie_d;
            ovf_q   <= ovf_d;
            ev_q    <= event_i;
        end
    end
endmodule

// File: tb/tb_riscv_perf_counter_unit.sv
// Scoreboard bench for riscv_perf_counter_unit: expected values queued at stimulus, popped at sampling.
module tb_riscv_perf_counter_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        csr_access_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic [1:0]  csr_op_i;
    logic [31:0] csr_rdata_o;
    logic        csr_hit_o;
    logic [15:0] event_i;
    logic        ovf_irq_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    riscv_perf_counter_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .csr_access_i (csr_access_i),
        .csr_addr_i   (csr_addr_i),
        .csr_wdata_i  (csr_wdata_i),
        .csr_op_i     (csr_op_i),
        .csr_rdata_o  (csr_rdata_o),
        .csr_hit_o    (csr_hit_o),
        .event_i      (event_i),
        .ovf_irq_o    (ovf_irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata);
        csr_access_i = 1'b1;
        csr_op_i     = op;
        csr_addr_i   = addr;
        csr_wdata_i  = wdata;
        $display("wr op=%0d addr=%h data=%h", op, addr, wdata);
        cyc();
        csr_access_i = 1'b0;
        csr_op_i     = 2'b00;
    endtask

    task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string tag);
        logic [31:0] e;
        string       t;
        csr_access_i = 1'b1;
        csr_op_i     = 2'b00;
        csr_addr_i   = addr;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        $display("rd %s addr=%h data=%h", t, addr, csr_rdata_o);
        check(t, csr_rdata_o, e);
        cyc();
        csr_access_i = 1'b0;
    endtask

    task automatic rd_miss(input logic [11:0] addr, input string tag);
        logic [31:0] e;
        string       t;
        csr_access_i = 1'b1;
        csr_op_i     = 2'b01;
        csr_addr_i   = addr;
        csr_wdata_i  = 32'hFFFF_FFFF;
        exp_q.push_back(32'd0);
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        $display("rd %s addr=%h data=%h hit=%0d", t, addr, csr_rdata_o, csr_hit_o);
        check({t, "_data"}, csr_rdata_o, e);
        check({t, "_hit"}, {31'd0, csr_hit_o}, e);
        cyc();
        csr_access_i = 1'b0;
        csr_op_i     = 2'b00;
    endtask

    task automatic chk_irq(input logic exp, input string tag);
        logic [31:0] e;
        string       t;
        exp_q.push_back({31'd0, exp});
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        $display("irq %s value=%0d", t, ovf_irq_o);
        check(t, {31'd0, ovf_irq_o}, e);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        csr_access_i = 1'b0;
        csr_addr_i   = '0;
        csr_wdata_i  = '0;
        csr_op_i     = 2'b00;
        event_i      = '0;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();

        rd(12'h7A1, 32'h1, "rst_ctrl");
        rd(12'h790, 32'hFF, "rst_evsel0");
        rd(12'h7A3, 32'h0, "rst_ovf");
        rd(12'h780, 32'h0, "rst_cnt0");
        chk_irq(1'b0, "rst_irq");

        csr_wr(2'b01, 12'h790, 32'h3);
        event_i = 16'h0008;
        rd(12'h780, 32'd0, "cnt_t0");
        rd(12'h780, 32'd0, "cnt_t1");
        rd(12'h780, 32'd1, "cnt_t2");
        rd(12'h780, 32'd2, "cnt_t3");
        rd(12'h780, 32'd3, "cnt_t4");
        event_i = 16'h0000;
        rd(12'h780, 32'd4, "cnt_t5");
        rd(12'h780, 32'd5, "cnt_t6");
        rd(12'h780, 32'd5, "cnt_hold");
        rd(12'h781, 32'd0, "cnt1_disabled");

        csr_wr(2'b01, 12'h7A1, 32'h1);
        csr_wr(2'b01, 12'h780, 32'hFFFF_FFFF);
        csr_wr(2'b01, 12'h788, 32'h0000_FFFF);
        csr_wr(2'b01, 12'h7A2, 32'h1);
        event_i = 16'h0008;
        cyc();
        event_i = 16'h0000;
        chk_irq(1'b0, "wrap_irq_t1");
        chk_irq(1'b1, "wrap_irq_t2");
        rd(12'h780, 32'h0, "wrap_lo");
        rd(12'h788, 32'h0, "wrap_hi");
        rd(12'h7A3, 32'h1, "wrap_ovf");
        csr_wr(2'b11, 12'h7A3, 32'h1);
        chk_irq(1'b0, "irq_cleared");

        csr_wr(2'b01, 12'h7A1, 32'h3);
        csr_wr(2'b01, 12'h780, 32'hFFFF_FFFF);
        csr_wr(2'b01, 12'h788, 32'h0000_FFFF);
        event_i = 16'h0008;
        repeat (3) cyc();
        event_i = 16'h0000;
        repeat (2) cyc();
        rd(12'h780, 32'hFFFF_FFFF, "sat_lo");
        rd(12'h788, 32'h0000_FFFF, "sat_hi");
        rd(12'h7A3, 32'h1, "sat_ovf");

        csr_wr(2'b01, 12'h7A1, 32'h1);
        csr_wr(2'b01, 12'h788, 32'h0);
        csr_wr(2'b01, 12'h780, 32'h0);
        csr_wr(2'b11, 12'h7A3, 32'h1);
        event_i = 16'h0008;
        cyc();
        event_i = 16'h0000;
        csr_wr(2'b01, 12'h780, 32'h10);
        rd(12'h780, 32'h10, "coll_lo");
        rd(12'h788, 32'h0, "coll_hi");

        csr_wr(2'b10, 12'h7A3, 32'h1);
        csr_wr(2'b01, 12'h780, 32'hFFFF_FFFF);
        csr_wr(2'b01, 12'h788, 32'h0000_FFFF);
        event_i = 16'h0008;
        cyc();
        event_i = 16'h0000;
        csr_wr(2'b11, 12'h7A3, 32'h1);
        rd(12'h7A3, 32'h1, "ovf_set_wins");
        rd(12'h780, 32'h0, "ovf_coll_lo");

        csr_wr(2'b01, 12'h788, 32'h0);
        csr_wr(2'b01, 12'h780, 32'hFFFF_FFFF);
        rd(12'h780, 32'hFFFF_FFFF, "shadow_lo");
        event_i = 16'h0008;
        cyc();
        event_i = 16'h0000;
        repeat (2) cyc();
`ifdef PERF_SHADOW_READ_EN
        rd(12'h788, 32'h0, "shadow_hi");
`else
        rd(12'h788, 32'h1, "live_hi");
`endif
        rd(12'h780, 32'h0, "after_inc_lo");

        csr_wr(2'b01, 12'h791, 32'h10);
        csr_wr(2'b01, 12'h792, 32'h0F);
        event_i = 16'hFFFF;
        cyc();
        event_i = 16'h0000;
        repeat (2) cyc();
        rd(12'h781, 32'h0, "evsel_oor");
        rd(12'h782, 32'h1, "evsel_top");
        rd(12'h791, 32'h10, "evsel1_rb");

        csr_wr(2'b11, 12'h7A1, 32'h1);
        event_i = 16'hFFFF;
        cyc();
        event_i = 16'h0000;
        repeat (2) cyc();
        rd(12'h782, 32'h1, "en_off");

        rd_miss(12'h784, "miss_idx");
        rd_miss(12'h7A0, "miss_addr");

        csr_wr(2'b10, 12'h7A1, 32'h1);
        event_i = 16'hFFFF;
        cyc();
        event_i = 16'h0000;
        #2 rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        rd(12'h782, 32'h0, "midrst_cnt2");
        rd(12'h790, 32'hFF, "midrst_evsel0");
        rd(12'h7A1, 32'h1, "midrst_ctrl");
        rd(12'h7A3, 32'h0, "midrst_ovf");
        chk_irq(1'b0, "midrst_irq");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
